// File: rtl/triangular_mask_stream_if.sv
// Element stream bundle for triangular_mask_stream: valid/ready input side and
// valid/ready/last output side.
interface triangular_mask_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_tdata;
  logic                  in_tvalid;
  logic                  in_tready;
  logic [DATA_WIDTH-1:0] out_tdata;
  logic                  out_tvalid;
  logic                  out_tready;
  logic                  out_tlast;

  modport master (
    output in_tdata, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast
  );

  modport slave (
    input  in_tdata, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast
  );
endinterface

// File: rtl/triangular_mask_stream.sv
// Streams a row-major SIZE x SIZE matrix through a triangular/diagonal mask,
// dropping or zeroing masked elements, through a 2-entry output FIFO.
module triangular_mask_stream #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             mode,
  input  logic                   fill_zero,
  triangular_mask_stream_if.slave strm,
  output logic                   matrix_done
);
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);

  logic [CW-1:0]         row_q, row_d, col_q, col_d;
  logic [2:0]            mode_q, mode_d;
  logic                  fill_q, fill_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic [1:0]            cnt_q, cnt_d, cnt_after;
  logic                  rdy_q, rdy_d;

  logic                  accept, first, at_end, keep, last_kept, push, pop, push_last;
  logic                  row_last, col_last, row_pen, col_pen;
  logic [2:0]            eff_mode;
  logic                  eff_fill;
  logic [DATA_WIDTH-1:0] push_data;

  always_comb begin
    accept   = strm.in_tvalid & rdy_q;
    first    = (row_q == '0) && (col_q == '0);
    row_last = (row_q == LAST_IDX);
    col_last = (col_q == LAST_IDX);
    row_pen  = (SIZE >= 2) && (int'(row_q) == SIZE - 2);
    col_pen  = (SIZE >= 2) && (int'(col_q) == SIZE - 2);
    at_end   = row_last && col_last;
    // Element (0,0) already uses the mode it latches
    eff_mode = first ? mode : mode_q;
    eff_fill = first ? fill_zero : fill_q;

    case (eff_mode)
      3'd0:    keep = (row_q >= col_q);
      3'd1:    keep = (row_q <= col_q);
      3'd2:    keep = (row_q > col_q);
      3'd3:    keep = (row_q < col_q);
      3'd4:    keep = (row_q == col_q);
      default: keep = 1'b1;
    endcase

    case (eff_mode)
      3'd2:    last_kept = row_last && col_pen;
      3'd3:    last_kept = row_pen && col_last;
      default: last_kept = at_end;
    endcase

    push      = accept & (keep | eff_fill);
    push_data = keep ? strm.in_tdata : '0;
    push_last = eff_fill ? at_end : last_kept;
  end

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    mode_d = mode_q;
    fill_d = fill_q;
    done_d = accept & at_end;
    if (accept) begin
      if (first) begin
        mode_d = mode;
        fill_d = fill_zero;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Entry 0 is the output register; a pop shifts entry 1 forward before the push lands
  always_comb begin
    data0_d   = data0_q;
    last0_d   = last0_q;
    data1_d   = data1_q;
    last1_d   = last1_q;
    pop       = (cnt_q != 2'd0) & strm.out_tready;
    if (pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
    end
    cnt_after = cnt_q - {1'b0, pop};
    if (push) begin
      if (cnt_after == 2'd0) begin
        data0_d = push_data;
        last0_d = push_last;
      end else begin
        data1_d = push_data;
        last1_d = push_last;
      end
    end
    cnt_d = cnt_after + {1'b0, push};
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      mode_q  <= '0;
      fill_q  <= 1'b0;
      done_q  <= 1'b0;
      data0_q <= '0;
      last0_q <= 1'b0;
      data1_q <= '0;
      last1_q <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
      data0_q <= data0_d;
      last0_q <= last0_d;
      data1_q <= data1_d;
      last1_q <= last1_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign strm.in_tready  = rdy_q;
  assign strm.out_tvalid = (cnt_q != 2'd0);
  assign strm.out_tdata  = data0_q;
  assign strm.out_tlast  = last0_q & (cnt_q != 2'd0);
  assign matrix_done     = done_q;
endmodule
